// File: rtl/serial_packet_receiver_pkg.sv
// rtl/serial_packet_receiver_pkg.sv - shared frame layout, constants and state type for the serial receiver
package serial_packet_receiver_pkg;

    localparam int FRAME_W   = 80;
    localparam int START_POS = FRAME_W - 1;
    localparam int SRC_HI    = 78;
    localparam int SRC_LO    = 75;
    localparam int DST_HI    = 74;
    localparam int DST_LO    = 71;
    localparam int SIZE_HI   = 70;
    localparam int SIZE_LO   = 69;
    localparam int DATA_HI   = 68;
    localparam int DATA_LO   = 5;
    localparam int CRC_HI    = 4;
    localparam int CRC_LO    = 1;
    localparam int END_POS   = 0;

    // Wide enough to hold the highest bit position below the start bit.
    localparam int CNT_W = 7;

    localparam logic [3:0] CRC4_POLY  = 4'h3;
    localparam logic [3:0] BCAST_ADDR = 4'hF;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        CHECK     = 2'd3
    } rx_state_e;

    // One MSB-first step of the x^4+x+1 LFSR.
    function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic din);
        logic fb;
        fb = crc[3] ^ din;
        return {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'h0);
    endfunction

endpackage

// File: rtl/serial_packet_receiver_crc4.sv
// rtl/serial_packet_receiver_crc4.sv - bit-serial CRC-4 accumulator fed while the payload shifts in
module crc4_serial
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic [3:0] crc
);
    import serial_packet_receiver_pkg::*;

    logic [3:0] crc_q;
    logic [3:0] crc_d;

    // Clear wins over enable so a fresh frame always starts from 4'h0.
    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = 4'h0;
        end else if (en) begin
            crc_d = crc4_step(crc_q, din);
        end
    end

    // Remainder register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc_q <= 4'h0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/serial_packet_receiver.sv
// rtl/serial_packet_receiver.sv - bit-serial frame receiver with address/CRC check, payload buffer and ack
module serial_packet_receiver #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 64,
    parameter int ACK_CYCLES   = 2,
    parameter int BROADCAST_EN = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] node_address,
    input  logic              main_bus_in,
    output logic [DATA_W-1:0] rx_data,
    output logic [ADDR_W-1:0] rx_src,
    output logic [1:0]        rx_size,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              ack_out,
    output logic              crc_err,
    output logic              frame_err,
    output logic              overflow
);
    import serial_packet_receiver_pkg::*;

    localparam int ACK_W = $clog2(ACK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_FIRST   = CNT_W'(SRC_HI);
    localparam logic [CNT_W-1:0] CNT_DATA_HI = CNT_W'(DATA_HI);
    localparam logic [CNT_W-1:0] CNT_DATA_LO = CNT_W'(DATA_LO);
    localparam logic [ACK_W-1:0] ACK_LOAD    = ACK_W'(ACK_CYCLES);

    rx_state_e            state_q,    state_d;
    logic                 bus_q,      bus_d;
    logic [CNT_W-1:0]     bit_cnt_q,  bit_cnt_d;
    logic [START_POS-1:0] sreg_q,     sreg_d;
    logic [DATA_W-1:0]    rx_data_q,  rx_data_d;
    logic [ADDR_W-1:0]    rx_src_q,   rx_src_d;
    logic [1:0]           rx_size_q,  rx_size_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [ACK_W-1:0]     ack_cnt_q,  ack_cnt_d;

    logic              crc_clear;
    logic              crc_en;
    logic [3:0]        crc_calc;
    logic              accept;
    logic              accept_ack;
    logic              crc_err_o;
    logic              frame_err_o;
    logic              overflow_o;

    // Fields of the captured frame as seen in CHECK.
    logic [ADDR_W-1:0] f_src;
    logic [ADDR_W-1:0] f_dst;
    logic [1:0]        f_size;
    logic [DATA_W-1:0] f_data;
    logic [3:0]        f_crc;
    logic              f_end;
    logic              is_bcast;
    logic              addr_hit;

    assign f_src    = ADDR_W'(sreg_q[SRC_HI:SRC_LO]);
    assign f_dst    = ADDR_W'(sreg_q[DST_HI:DST_LO]);
    assign f_size   = sreg_q[SIZE_HI:SIZE_LO];
    assign f_data   = DATA_W'(sreg_q[DATA_HI:DATA_LO]);
    assign f_crc    = sreg_q[CRC_HI:CRC_LO];
    assign f_end    = sreg_q[END_POS];
    assign is_bcast = (BROADCAST_EN != 0) && (f_dst == ADDR_W'(BCAST_ADDR));
    assign addr_hit = (f_dst == node_address) || is_bcast;

    crc4_serial u_crc (
        .clock (clock),
        .reset (reset),
        .clear (crc_clear),
        .en    (crc_en),
        .din   (bus_q),
        .crc   (crc_calc)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a low bus only counts as a start once it has been seen high.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_IDLE: if (bus_q)  state_d = IDLE;
            IDLE:      if (!bus_q) state_d = SHIFT;
            SHIFT:     if (bit_cnt_q == '0) state_d = CHECK;
            CHECK:     state_d = WAIT_IDLE;
            default:   state_d = WAIT_IDLE;
        endcase
    end

    // FSM outputs: CRC control and the prioritised frame verdict in CHECK.
    always_comb begin
        crc_clear   = (state_q == IDLE);
        crc_en      = (state_q == SHIFT) && (bit_cnt_q <= CNT_DATA_HI) && (bit_cnt_q >= CNT_DATA_LO);
        frame_err_o = 1'b0;
        crc_err_o   = 1'b0;
        overflow_o  = 1'b0;
        accept      = 1'b0;
        if (state_q == CHECK) begin
            if (!f_end) begin
                frame_err_o = 1'b1;
            end else if (addr_hit) begin
                if (f_crc != crc_calc) begin
                    crc_err_o = 1'b1;
                end else if (rx_valid_q && !rx_ready) begin
                    overflow_o = 1'b1;
                end else begin
                    accept = 1'b1;
                end
            end
        end
        accept_ack = accept && !is_bcast;
    end

    // Deserialiser: bus sample register, bit counter and shift register.
    always_comb begin
        bus_d     = main_bus_in;
        bit_cnt_d = bit_cnt_q;
        sreg_d    = sreg_q;
        if (state_q == IDLE && !bus_q) begin
            bit_cnt_d = CNT_FIRST;
        end else if (state_q == SHIFT) begin
            sreg_d[bit_cnt_q] = bus_q;
            if (bit_cnt_q != '0) begin
                bit_cnt_d = bit_cnt_q - CNT_W'(1);
            end
        end
    end

    // Payload buffer and ack timer; a load in the same cycle as a take keeps rx_valid high.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_src_d   = rx_src_q;
        rx_size_d  = rx_size_q;
        rx_valid_d = rx_valid_q;
        ack_cnt_d  = ack_cnt_q;
        if (accept) begin
            rx_data_d  = f_data;
            rx_src_d   = f_src;
            rx_size_d  = f_size;
            rx_valid_d = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (accept_ack) begin
            ack_cnt_d = ACK_LOAD;
        end else if (ack_cnt_q != '0) begin
            ack_cnt_d = ack_cnt_q - ACK_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_q      <= 1'b0;
            bit_cnt_q  <= '0;
            sreg_q     <= '0;
            rx_data_q  <= '0;
            rx_src_q   <= '0;
            rx_size_q  <= '0;
            rx_valid_q <= 1'b0;
            ack_cnt_q  <= '0;
        end else begin
            bus_q      <= bus_d;
            bit_cnt_q  <= bit_cnt_d;
            sreg_q     <= sreg_d;
            rx_data_q  <= rx_data_d;
            rx_src_q   <= rx_src_d;
            rx_size_q  <= rx_size_d;
            rx_valid_q <= rx_valid_d;
            ack_cnt_q  <= ack_cnt_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_src    = rx_src_q;
    assign rx_size   = rx_size_q;
    assign rx_valid  = rx_valid_q;
    assign ack_out   = (ack_cnt_q != '0);
    assign crc_err   = crc_err_o;
    assign frame_err = frame_err_o;
    assign overflow  = overflow_o;

endmodule
